// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// AluShareArb (module alu_share_arb)
//
// Purpose:
//   Lets two requesters share one combinational ALU. A requester offers an
//   operation (operands A/B plus a 4-bit control code). The arbiter accepts
//   one request at a time and registers the operands onto the ALU drive
//   lines. One cycle later it captures the ALU result. It then presents that
//   result to the owning requester until the requester consumes it.
//   The arbiter runs one operation at a time, so an operation takes at least
//   three cycles: accept, execute, respond.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_ctrl  operation offered by requester N
//   rspN_valid / rspN_ready    response handshake for requester N
//   rsp_result/zero/lt         shared response payload; meaningful only
//                              while one of the rspN_valid outputs is high
//   alu_a, alu_b, alu_ctrl     registered drive to the shared ALU
//   alu_result/zero/lt         combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_share_arb #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [LEN-1:0] req0_a,
  input  logic [LEN-1:0] req0_b,
  input  logic [3:0]     req0_ctrl,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [LEN-1:0] req1_a,
  input  logic [LEN-1:0] req1_b,
  input  logic [3:0]     req1_ctrl,

  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [LEN-1:0] rsp_result,
  output logic           rsp_zero,
  output logic           rsp_lt,

  output logic [LEN-1:0] alu_a,
  output logic [LEN-1:0] alu_b,
  output logic [3:0]     alu_ctrl,
  input  logic [LEN-1:0] alu_result,
  input  logic           alu_zero,
  input  logic           alu_lt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_t;

  arbState_t      r_state;
  logic           r_lastGrant;
  logic           r_owner;
  logic [LEN-1:0] r_aluA;
  logic [LEN-1:0] r_aluB;
  logic [3:0]     r_aluCtrl;
  logic [LEN-1:0] r_rspResult;
  logic           r_rspZero;
  logic           r_rspLt;
  logic           r_rsp0Valid;
  logic           r_rsp1Valid;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept0;
  logic           w_accept1;
  logic           w_rspDone;

  // Grant selection. A lone valid requester always wins. On a tie, the
  // requester that did not win last time wins. Both terms depend on the
  // current valids, so the two grants can never both be high.
  always_comb begin
    w_grant0 = req0_valid && (!req1_valid || r_lastGrant);
    w_grant1 = req1_valid && (!req0_valid || !r_lastGrant);
  end

  // Ready is offered only while idle and never while reset is being applied.
  // The reset term keeps ready low during reset, before the state register
  // has been cleared.
  always_comb begin
    req0_ready = rst_n && (r_state == IDLE) && w_grant0;
    req1_ready = rst_n && (r_state == IDLE) && w_grant1;
  end

  // An accept is the valid/ready handshake itself. A request that drops
  // before it is granted leaves nothing behind.
  always_comb begin
    w_accept0 = req0_valid && req0_ready;
    w_accept1 = req1_valid && req1_ready;
  end

  // The response completes only when the owner's own ready matches its valid.
  // The other requester's ready is ignored because its valid is low.
  always_comb begin
    w_rspDone = (r_rsp0Valid && rsp0_ready) || (r_rsp1Valid && rsp1_ready);
  end

  // Single FSM register block. The ALU drive registers change only on an
  // accept edge, so the ALU sees stable operands for the rest of the
  // operation. The response payload is captured once in EXEC and held
  // through RESP, however long back-pressure lasts. A reset in EXEC or RESP
  // clears everything, so the aborted result can never be delivered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCtrl   <= '0;
      r_rspResult <= '0;
      r_rspZero   <= 1'b0;
      r_rspLt     <= 1'b0;
      r_rsp0Valid <= 1'b0;
      r_rsp1Valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept0) begin
            r_aluA      <= req0_a;
            r_aluB      <= req0_b;
            r_aluCtrl   <= req0_ctrl;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b0;
            r_state     <= EXEC;
          end else if (w_accept1) begin
            r_aluA      <= req1_a;
            r_aluB      <= req1_b;
            r_aluCtrl   <= req1_ctrl;
            r_owner     <= 1'b1;
            r_lastGrant <= 1'b1;
            r_state     <= EXEC;
          end
        end

        // The ALU has had a full cycle to settle on the registered
        // operands. Its outputs are sampled as-is. Undefined control codes
        // are not filtered, so the caller gets whatever the ALU produces.
        EXEC: begin
          r_rspResult <= alu_result;
          r_rspZero   <= alu_zero;
          r_rspLt     <= alu_lt;
          r_rsp0Valid <= !r_owner;
          r_rsp1Valid <= r_owner;
          r_state     <= RESP;
        end

        RESP: begin
          if (w_rspDone) begin
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output mapping. Every response and ALU-drive output comes directly from
  // a register.
  always_comb begin
    alu_a      = r_aluA;
    alu_b      = r_aluB;
    alu_ctrl   = r_aluCtrl;
    rsp_result = r_rspResult;
    rsp_zero   = r_rspZero;
    rsp_lt     = r_rspLt;
    rsp0_valid = r_rsp0Valid;
    rsp1_valid = r_rsp1Valid;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// TbAluShareArb (module tb_alu_share_arb)
//
// Purpose:
//   Directed bench for alu_share_arb. A small combinational ALU model sits on
//   the alu_* lines. Each step drives requests and response readies, and the
//   outputs are compared against hand-computed values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

  localparam int LEN = 32;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  logic           clk;
  logic           rst_n;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [LEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]     req0_ctrl, req1_ctrl;
  logic           rsp0_valid, rsp1_valid;
  logic           rsp0_ready, rsp1_ready;
  logic [LEN-1:0] rsp_result;
  logic           rsp_zero, rsp_lt;
  logic [LEN-1:0] alu_a, alu_b;
  logic [3:0]     alu_ctrl;
  logic [LEN-1:0] alu_result;
  logic           alu_zero, alu_lt;

  int nVec;
  int nMis;

  alu_share_arb #(.LEN(LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_lt     (rsp_lt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU. Undefined control codes give result 0, zero 1, lt 0.
  always_comb begin
    alu_result = '0;
    alu_lt     = 1'b0;
    unique case (alu_ctrl)
      CTRL_AND: alu_result = alu_a & alu_b;
      CTRL_OR:  alu_result = alu_a | alu_b;
      CTRL_ADD: alu_result = alu_a + alu_b;
      CTRL_SUB: alu_result = alu_a - alu_b;
      CTRL_SLT: alu_result = {{(LEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default:  alu_result = '0;
    endcase
    if (alu_ctrl inside {CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT})
      alu_lt = $signed(alu_a) < $signed(alu_b);
    alu_zero = (alu_result == '0);
  end

  // Advance one clock. Leaves time 1 unit past the rising edge, so sampling
  // and driving both happen away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both request channels in one call.
  task automatic applyStimulus(
    input logic           v0, input logic [LEN-1:0] a0, input logic [LEN-1:0] b0, input logic [3:0] c0,
    input logic           v1, input logic [LEN-1:0] a1, input logic [LEN-1:0] b1, input logic [3:0] c1
  );
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
  endtask

  task automatic checkOutput(input string tag, input logic [LEN-1:0] observed,
                             input logic [LEN-1:0] expected);
    nVec++;
    assert (observed === expected)
    else begin
      nMis++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    rst_n = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Both requests are pending during reset: ready must stay low.
    applyStimulus(1'b1, 32'd5, 32'd7, CTRL_ADD, 1'b1, 32'd1, 32'd2, CTRL_ADD);
    tick();
    tick();
    checkOutput("rstReady0",  32'(req0_ready), 32'd0);
    checkOutput("rstReady1",  32'(req1_ready), 32'd0);
    checkOutput("rstRsp0V",   32'(rsp0_valid), 32'd0);
    checkOutput("rstRsp1V",   32'(rsp1_valid), 32'd0);
    checkOutput("rstAluA",    alu_a,           32'd0);
    checkOutput("rstResult",  rsp_result,      32'd0);

    // Single op: req0 ADD 5+7.
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'd5, 32'd7, CTRL_ADD, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b1;
    #1;
    checkOutput("singleReady0", 32'(req0_ready), 32'd1);
    checkOutput("singleReady1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    checkOutput("singleAluA",    alu_a,           32'd5);
    checkOutput("singleAluB",    alu_b,           32'd7);
    checkOutput("singleAluCtrl", 32'(alu_ctrl),   32'(CTRL_ADD));
    checkOutput("singleRspEarly",32'(rsp0_valid), 32'd0);
    tick();
    checkOutput("singleRsp0V",   32'(rsp0_valid), 32'd1);
    checkOutput("singleRsp1V",   32'(rsp1_valid), 32'd0);
    checkOutput("singleResult",  rsp_result,      32'd12);
    checkOutput("singleZero",    32'(rsp_zero),   32'd0);
    tick();
    checkOutput("singleRspDone", 32'(rsp0_valid), 32'd0);
    req0_valid = 1'b1;
    #1;
    checkOutput("singleReadyAgain", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;

    // Tie after a fresh reset: req0 SUB 9-9 wins first, then req1 SLT -1<1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'd9, 32'd9, CTRL_SUB, 1'b1, 32'hFFFF_FFFF, 32'd1, CTRL_SLT);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b0;
    #1;
    checkOutput("tieReady0", 32'(req0_ready), 32'd1);
    checkOutput("tieReady1", 32'(req1_ready), 32'd0);
    tick();
    checkOutput("execReady0", 32'(req0_ready), 32'd0);
    checkOutput("execReady1", 32'(req1_ready), 32'd0);
    tick();
    checkOutput("tieRsp0V",   32'(rsp0_valid), 32'd1);
    checkOutput("tieRsp1V",   32'(rsp1_valid), 32'd0);
    checkOutput("tieResult0", rsp_result,      32'd0);
    checkOutput("tieZero0",   32'(rsp_zero),   32'd1);
    tick();
    checkOutput("altReady1", 32'(req1_ready), 32'd1);
    checkOutput("altReady0", 32'(req0_ready), 32'd0);
    tick();
    checkOutput("sltAluCtrl", 32'(alu_ctrl), 32'(CTRL_SLT));
    tick();
    checkOutput("sltRsp1V",   32'(rsp1_valid), 32'd1);
    checkOutput("sltRsp0V",   32'(rsp0_valid), 32'd0);
    checkOutput("sltResult",  rsp_result,      32'd1);
    checkOutput("sltLt",      32'(rsp_lt),     32'd1);

    // Back-pressure on rsp1 for 5 cycles. rsp0_ready stays high and must be
    // ignored because rsp0_valid is low.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bpRsp1V_%0d", i),   32'(rsp1_valid), 32'd1);
      checkOutput($sformatf("bpResult_%0d", i),  rsp_result,      32'd1);
      checkOutput($sformatf("bpLt_%0d", i),      32'(rsp_lt),     32'd1);
      checkOutput($sformatf("bpReady0_%0d", i),  32'(req0_ready), 32'd0);
      checkOutput($sformatf("bpReady1_%0d", i),  32'(req1_ready), 32'd0);
      checkOutput($sformatf("bpAluA_%0d", i),    alu_a,           32'hFFFF_FFFF);
      checkOutput($sformatf("bpAluCtrl_%0d", i), 32'(alu_ctrl),   32'(CTRL_SLT));
    end
    rsp1_ready = 1'b1;
    tick();
    checkOutput("bpRsp1Done", 32'(rsp1_valid), 32'd0);
    checkOutput("altBack0",   32'(req0_ready), 32'd1);
    checkOutput("altBack1",   32'(req1_ready), 32'd0);

    // Reset while in RESP aborts the op. Afterwards a tie goes to req0.
    tick();
    tick();
    checkOutput("abortRsp0V", 32'(rsp0_valid), 32'd1);
    rsp0_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("abortRsp0Clr",  32'(rsp0_valid), 32'd0);
    checkOutput("abortRsp1Clr",  32'(rsp1_valid), 32'd0);
    checkOutput("abortAluA",     alu_a,           32'd0);
    checkOutput("abortAluCtrl",  32'(alu_ctrl),   32'd0);
    checkOutput("abortResult",   rsp_result,      32'd0);
    checkOutput("abortZero",     32'(rsp_zero),   32'd0);
    checkOutput("abortReady0",   32'(req0_ready), 32'd0);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    #1;
    checkOutput("postRstTie0", 32'(req0_ready), 32'd1);
    checkOutput("postRstTie1", 32'(req1_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
    checkOutput("noStaleRsp0", 32'(rsp0_valid), 32'd0);
    checkOutput("noStaleRsp1", 32'(rsp1_valid), 32'd0);

    // Undefined control code 4'b1111 from req1 passes straight through to
    // the ALU.
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd3, 32'd9, 4'b1111);
    rsp1_ready = 1'b1;
    #1;
    checkOutput("illReady1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    checkOutput("illAluCtrl", 32'(alu_ctrl),   32'hF);
    checkOutput("illEarly",   32'(rsp1_valid), 32'd0);
    tick();
    checkOutput("illRsp1V",   32'(rsp1_valid), 32'd1);
    checkOutput("illResult",  rsp_result,      32'd0);
    checkOutput("illZero",    32'(rsp_zero),   32'd1);
    checkOutput("illLt",      32'(rsp_lt),     32'd0);
    tick();
    checkOutput("illDone",    32'(rsp1_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
